// File: rtl/bcd_7seg_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : bcd_7seg_pkg                                           |
// | Description : Shared glyph constants and types for the bcd_7seg      |
// |               seven-segment decoder. Glyphs are active-low, bit      |
// |               order g..a (bit 6 = g, bit 0 = a).                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_7seg_pkg;

   // One digit's segment drives, active-low, {g,f,e,d,c,b,a}
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;  // 6 with tail on segment a
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0011000;  // 9 without tail on segment d
   localparam seg_t SEG_A     = 7'b0001000;
   localparam seg_t SEG_B     = 7'b0000011;  // lower-case b
   localparam seg_t SEG_C     = 7'b1000110;
   localparam seg_t SEG_D     = 7'b0100001;  // lower-case d
   localparam seg_t SEG_E     = 7'b0000110;
   localparam seg_t SEG_F     = 7'b0001110;

   localparam seg_t SEG_BLANK = 7'b1111111;  // all segments off
   localparam seg_t SEG_ALL   = 7'b0000000;  // all segments on
   localparam seg_t SEG_DASH  = 7'b0111111;  // middle bar (g) only

   // Full 16-entry glyph lookup. Whether codes 10-15 may actually be
   // shown is decided by the caller; the default keeps any unexpected
   // value from producing X.
   function automatic seg_t digit_glyph(input logic [3:0] n);
      seg_t g;
      case (n)
         4'd0:    g = SEG_0;
         4'd1:    g = SEG_1;
         4'd2:    g = SEG_2;
         4'd3:    g = SEG_3;
         4'd4:    g = SEG_4;
         4'd5:    g = SEG_5;
         4'd6:    g = SEG_6;
         4'd7:    g = SEG_7;
         4'd8:    g = SEG_8;
         4'd9:    g = SEG_9;
         4'd10:   g = SEG_A;
         4'd11:   g = SEG_B;
         4'd12:   g = SEG_C;
         4'd13:   g = SEG_D;
         4'd14:   g = SEG_E;
         4'd15:   g = SEG_F;
         default: g = SEG_DASH;
      endcase
      return g;
   endfunction

endpackage : bcd_7seg_pkg

`default_nettype wire

// File: rtl/bcd_7seg_dec.sv
// +----------------------------------------------------------------------+
// | Module      : bcd_7seg_dec                                           |
// | Description : Purely combinational num -> {seg, err} lookup.         |
// |               Build option BCD7SEG_HEX_EN: when defined, codes 10-15 |
// |               show hex glyphs A b C d E F with err=0; otherwise they |
// |               show a dash with err=1.                                |
// | Ports       : num [3:0] in  - value to decode                        |
// |               seg [6:0] out - active-low segments, g..a              |
// |               err       out - 1 when num is not displayable          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_7seg_dec
   import bcd_7seg_pkg::*;
(
   input  logic [3:0] num,
   output logic [6:0] seg,
   output logic       err
);

   always_comb begin
      seg = SEG_DASH;
      err = 1'b0;
`ifdef BCD7SEG_HEX_EN
      seg = digit_glyph(num);
`else
      if (num <= 4'd9) begin
         seg = digit_glyph(num);
      end else begin
         seg = SEG_DASH;
         err = 1'b1;
      end
`endif
   end

endmodule : bcd_7seg_dec

`default_nettype wire

// File: rtl/bcd_7seg.sv
// +----------------------------------------------------------------------+
// | Module      : bcd_7seg                                               |
// | Description : Registered BCD-to-seven-segment decoder for one        |
// |               common-anode (active-low) digit, with blanking, lamp   |
// |               test and a non-BCD error flag. One cycle latency.      |
// |               Build option BCD7SEG_HEX_EN enables hex glyphs for     |
// |               codes 10-15 (applied inside bcd_7seg_dec).             |
// | Ports       : clk            in  - system clock, rising edge         |
// |               rst            in  - synchronous active-high reset     |
// |               num [3:0]      in  - value to display                  |
// |               blank          in  - 1 = all segments off              |
// |               lamp_test      in  - 1 = all segments on               |
// |               seg [6:0]      out - active-low segments, seg[0]=a     |
// |               err            out - registered num not displayable    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_7seg
   import bcd_7seg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] num,
   input  logic       blank,
   input  logic       lamp_test,
   output logic [6:0] seg,
   output logic       err
);

   seg_t r_seg;
   logic r_err;
   seg_t w_dec_seg;
   logic w_dec_err;

   bcd_7seg_dec u_dec (
      .num (num),
      .seg (w_dec_seg),
      .err (w_dec_err)
   );

   // Priority: rst > lamp_test > blank > decode. Display overrides
   // mask err because nothing of num is being shown.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg <= SEG_BLANK;
         r_err <= 1'b0;
      end else if (lamp_test) begin
         r_seg <= SEG_ALL;
         r_err <= 1'b0;
      end else if (blank) begin
         r_seg <= SEG_BLANK;
         r_err <= 1'b0;
      end else begin
         r_seg <= w_dec_seg;
         r_err <= w_dec_err;
      end
   end

   assign seg = r_seg;
   assign err = r_err;

endmodule : bcd_7seg

`default_nettype wire

// File: tb/tb_bcd_7seg.sv
// +----------------------------------------------------------------------+
// | Module      : tb_bcd_7seg                                            |
// | Description : Scoreboard bench for bcd_7seg. The driver applies a    |
// |               vector on the falling edge and queues the response     |
// |               expected after the next rising edge; the monitor pops  |
// |               and compares just after each rising edge.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bcd_7seg;

   logic       clk;
   logic       rst;
   logic [3:0] num;
   logic       blank;
   logic       lamp_test;
   logic [6:0] seg;
   logic       err;

   typedef struct {
      logic [6:0] seg;
      logic       err;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Hand-written glyph table, g..a, active-low
   logic [6:0] glyph [0:15];

   bcd_7seg dut (
      .clk       (clk),
      .rst       (rst),
      .num       (num),
      .blank     (blank),
      .lamp_test (lamp_test),
      .seg       (seg),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one DUT response per rising edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (seg !== e.seg) begin
            n_errors++;
            $display("FAIL %s seg: got %b want %b", e.name, seg, e.seg);
         end
         n_checks++;
         if (err !== e.err) begin
            n_errors++;
            $display("FAIL %s err: got %b want %b", e.name, err, e.err);
         end
      end
   end

   task automatic step(input logic r, input logic lt, input logic bl,
                       input logic [3:0] n, input logic [6:0] es,
                       input logic ee, input string nm);
      exp_t e;
      @(negedge clk);
      rst       = r;
      lamp_test = lt;
      blank     = bl;
      num       = n;
      e.seg  = es;
      e.err  = ee;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] hex_seg;
      logic       hex_err;

      glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001;
      glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
      glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
      glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
      glyph[8]  = 7'b0000000; glyph[9]  = 7'b0011000;
      glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
      glyph[12] = 7'b1000110; glyph[13] = 7'b0100001;
      glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

      rst = 1'b1; lamp_test = 1'b0; blank = 1'b0; num = 4'd8;

      // Reset held two cycles with num=8, then first decode of 8
      step(1, 0, 0, 4'd8, 7'b1111111, 0, "reset0");
      step(1, 0, 0, 4'd8, 7'b1111111, 0, "reset1");
      step(0, 0, 0, 4'd8, 7'b0000000, 0, "post_reset_8");

      // Valid BCD sweep
      for (int i = 0; i < 10; i++)
         step(0, 0, 0, 4'(i), glyph[i], 0, $sformatf("digit%0d", i));

      // Non-BCD codes: dash+err, or hex glyph in the hex build
      for (int i = 10; i < 16; i++) begin
`ifdef BCD7SEG_HEX_EN
         hex_seg = glyph[i];
         hex_err = 1'b0;
`else
         hex_seg = 7'b0111111;
         hex_err = 1'b1;
`endif
         step(0, 0, 0, 4'(i), hex_seg, hex_err, $sformatf("code%0d", i));
      end

      // Blank then release
      step(0, 0, 1, 4'd3, 7'b1111111, 0, "blank3");
      step(0, 0, 0, 4'd3, 7'b0110000, 0, "unblank3");
      // Blank masks err on a non-BCD code
      step(0, 0, 1, 4'd13, 7'b1111111, 0, "blank13");
      // Lamp test wins over blank
      step(0, 1, 1, 4'd11, 7'b0000000, 0, "lamp_blank11");
      // Lamp test alone masks err
      step(0, 1, 0, 4'd12, 7'b0000000, 0, "lamp12");
      // Reset beats lamp test
      step(1, 1, 0, 4'd7, 7'b1111111, 0, "rst_over_lamp");

      // Mid-stream reset with num=5, then hold
      step(0, 0, 0, 4'd5, 7'b0010010, 0, "five");
      step(1, 0, 0, 4'd5, 7'b1111111, 0, "rst_mid");
      step(0, 0, 0, 4'd5, 7'b0010010, 0, "after_rst5");
      step(0, 0, 0, 4'd5, 7'b0010010, 0, "hold5");
      step(0, 0, 0, 4'd6, 7'b0000010, 0, "six_tail");

      // Let the monitor drain the queue
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_bcd_7seg

`default_nettype wire
